rider_steer_seq: RTL and testbench



---
 rtl/rider_steer_seq.sv | 114 +++++++++++
 tb/tb_rider_steer_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rider_steer_seq.sv
// Rider-presence and steering-enable sequencer for balance_cntrl.
// Qualifies a level stance on the platform load cells before granting steering.
module rider_steer_seq #(
   parameter int          fast_sim     = 1,
   parameter logic [11:0] MIN_RIDER_WT = 12'h200,
   parameter logic [7:0]  WT_HYST      = 8'h40
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pwr_up,
   input  logic [11:0] lft_ld,
   input  logic [11:0] rght_ld,
   input  logic        ld_vld,
   output logic        rider_off,
   output logic        en_steer,
   output logic [12:0] wt_sum
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] STEER = 2'd2;

   localparam logic [11:0] FALL_WT = MIN_RIDER_WT - {4'b0, WT_HYST};

   logic [11:0] lft_r;
   logic [11:0] rght_r;
   logic [11:0] diff;
   logic [16:0] sum_x15;
   logic        sum_gt_min;
   logic        sum_lt_min;
   logic        diff_gt_1_4;
   logic        diff_gt_15_16;
   logic [25:0] tmr;
   logic        tmr_full;
   logic        clr_tmr;
   logic [1:0]  state;
   logic [1:0]  nxt_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_r  <= 12'h000;
         rght_r <= 12'h000;
      end else if (ld_vld) begin
         lft_r  <= lft_ld;
         rght_r <= rght_ld;
      end
   end

   assign wt_sum  = {1'b0, lft_r} + {1'b0, rght_r};
   assign diff    = (lft_r >= rght_r) ? (lft_r - rght_r) : (rght_r - lft_r);
   assign sum_x15 = {4'b0, wt_sum} * 17'd15;

   assign sum_gt_min    = wt_sum > {1'b0, MIN_RIDER_WT};
   assign sum_lt_min    = wt_sum < {1'b0, FALL_WT};
   assign diff_gt_1_4   = {1'b0, diff} > (wt_sum >> 2);
   assign diff_gt_15_16 = {5'b0, diff} > (sum_x15 >> 4);

   // Saturating qualification timer; every clr_tmr restarts the full interval.
   assign tmr_full = (fast_sim != 0) ? (&tmr[14:0]) : (&tmr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tmr <= 26'd0;
      else if (clr_tmr)
         tmr <= 26'd0;
      else if (!tmr_full)
         tmr <= tmr + 26'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      clr_tmr   = 1'b0;
      if (!pwr_up) begin
         nxt_state = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (sum_gt_min) begin
                  nxt_state = WAIT;
                  clr_tmr   = 1'b1;
               end
            end
            WAIT: begin
               if (sum_lt_min)
                  nxt_state = IDLE;
               else if (diff_gt_1_4)
                  clr_tmr = 1'b1;
               else if (tmr_full)
                  nxt_state = STEER;
            end
            STEER: begin
               if (sum_lt_min) begin
                  nxt_state = IDLE;
               end else if (diff_gt_15_16) begin
                  nxt_state = WAIT;
                  clr_tmr   = 1'b1;
               end
            end
            default: nxt_state = IDLE;
         endcase
      end
   end

   assign rider_off = (state == IDLE);
   assign en_steer  = (state == STEER);

endmodule

// File: tb/tb_rider_steer_seq.sv
// Self-checking bench for rider_steer_seq: a stance model compared every cycle,
// plus hand-computed literal checkpoints along a directed ride scenario.
module tb_rider_steer_seq;

   localparam int MIN_WT  = 512;
   localparam int FALL_WT = 448;
   localparam int QUAL    = 32768;

   logic        clk;
   logic        rst_n;
   logic        pwr_up;
   logic [11:0] lft_ld;
   logic [11:0] rght_ld;
   logic        ld_vld;
   logic        rider_off;
   logic        en_steer;
   logic [12:0] wt_sum;

   rider_steer_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pwr_up    (pwr_up),
      .lft_ld    (lft_ld),
      .rght_ld   (rght_ld),
      .ld_vld    (ld_vld),
      .rider_off (rider_off),
      .en_steer  (en_steer),
      .wt_sum    (wt_sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: stance phase plus the edge at which the current level interval began.
   typedef enum int {M_IDLE, M_WAIT, M_STEER} phase_t;

   phase_t m_phase;
   int     m_lft;
   int     m_rght;
   int     edge_no;
   int     qual_start;

   function automatic int m_sum();
      return m_lft + m_rght;
   endfunction

   function automatic int m_diff();
      return (m_lft > m_rght) ? (m_lft - m_rght) : (m_rght - m_lft);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase    <= M_IDLE;
         m_lft      <= 0;
         m_rght     <= 0;
         edge_no    <= 0;
         qual_start <= 0;
      end else begin
         edge_no <= edge_no + 1;
         if (!pwr_up) begin
            m_phase <= M_IDLE;
         end else begin
            case (m_phase)
               M_IDLE:
                  if (m_sum() > MIN_WT) begin
                     m_phase    <= M_WAIT;
                     qual_start <= edge_no + 1;
                  end
               M_WAIT:
                  if (m_sum() < FALL_WT)
                     m_phase <= M_IDLE;
                  else if (m_diff() > m_sum() / 4)
                     qual_start <= edge_no + 1;
                  else if ((edge_no + 1) - qual_start >= QUAL)
                     m_phase <= M_STEER;
               default:
                  if (m_sum() < FALL_WT) begin
                     m_phase <= M_IDLE;
                  end else if (m_diff() > (m_sum() * 15) / 16) begin
                     m_phase    <= M_WAIT;
                     qual_start <= edge_no + 1;
                  end
            endcase
         end
         if (ld_vld) begin
            m_lft  <= int'(lft_ld);
            m_rght <= int'(rght_ld);
         end
      end
   end

   int    n_cmp = 0;
   int    n_bad = 0;
   int    lit_seq = 0;
   int    lit_done = 0;
   string lit_name;
   logic  lit_rider;
   logic  lit_en;
   logic [12:0] lit_sum;
   event  lit_ev;

   task automatic checkOutput(input string name, input logic exp_rider,
                              input logic exp_en, input logic [12:0] exp_sum);
      n_cmp++;
      if (rider_off !== exp_rider || en_steer !== exp_en || wt_sum !== exp_sum) begin
         n_bad++;
         $display("[TB] FAIL %s at %0t: rider_off=%b en_steer=%b wt_sum=%h, required rider_off=%b en_steer=%b wt_sum=%h",
                  name, $time, rider_off, en_steer, wt_sum, exp_rider, exp_en, exp_sum);
      end
   endtask

   // Single compare process: literal checkpoints on request, model every cycle.
   initial forever begin
      @(negedge clk or lit_ev);
      if (lit_seq != lit_done) begin
         checkOutput(lit_name, lit_rider, lit_en, lit_sum);
         lit_done = lit_seq;
      end
      checkOutput("model", m_phase == M_IDLE, m_phase == M_STEER, 13'(m_sum()));
   end

   task automatic expectLiteral(input string name, input logic r, input logic e,
                                input logic [12:0] s);
      #1;
      lit_name  = name;
      lit_rider = r;
      lit_en    = e;
      lit_sum   = s;
      lit_seq   = lit_seq + 1;
      -> lit_ev;
      #1;
   endtask

   // Presents one load sample (or a bare pwr_up change when vld=0) for one edge.
   task automatic applyStimulus(input logic [11:0] l, input logic [11:0] r,
                                input logic vld, input logic pwr);
      @(negedge clk);
      lft_ld  = l;
      rght_ld = r;
      ld_vld  = vld;
      pwr_up  = pwr;
      @(negedge clk);
      ld_vld  = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n   = 1'b0;
      pwr_up  = 1'b0;
      lft_ld  = 12'h000;
      rght_ld = 12'h000;
      ld_vld  = 1'b0;
      expectLiteral("reset_init", 1'b1, 1'b0, 13'h000);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      waitCycles(2);

      // Mount: level 0x180/0x180
      applyStimulus(12'h180, 12'h180, 1'b1, 1'b1);
      expectLiteral("mount_sum", 1'b1, 1'b0, 13'h300);
      waitCycles(1);
      expectLiteral("mount_wait", 1'b0, 1'b0, 13'h300);
      waitCycles(QUAL - 1);
      expectLiteral("steer_early", 1'b0, 1'b0, 13'h300);
      waitCycles(1);
      expectLiteral("steer_on", 1'b0, 1'b1, 13'h300);

      // Steer drop: diff 1000 > 952
      applyStimulus(12'h3F0, 12'h008, 1'b1, 1'b1);
      expectLiteral("drop_sum", 1'b0, 1'b1, 13'h3F8);
      waitCycles(1);
      expectLiteral("drop_wait", 1'b0, 1'b0, 13'h3F8);

      // Unbalanced in WAIT: diff 0x280 > 0xE0 keeps the timer cleared
      applyStimulus(12'h300, 12'h080, 1'b1, 1'b1);
      waitCycles(1000);
      expectLiteral("unbal_hold", 1'b0, 1'b0, 13'h380);

      // Rebalance: full interval counted from the rebalance edge
      applyStimulus(12'h1C0, 12'h1C0, 1'b1, 1'b1);
      waitCycles(QUAL - 1);
      expectLiteral("rebal_early", 1'b0, 1'b0, 13'h380);
      waitCycles(1);
      expectLiteral("rebal_on", 1'b0, 1'b1, 13'h380);

      // Hysteresis band in STEER: 0x1D0 holds
      applyStimulus(12'h0E8, 12'h0E8, 1'b1, 1'b1);
      waitCycles(5);
      expectLiteral("hyst_hold", 1'b0, 1'b1, 13'h1D0);

      // Power loss with a simultaneous load capture, then power back
      applyStimulus(12'h1C0, 12'h1C0, 1'b1, 1'b0);
      expectLiteral("pwr_loss", 1'b1, 1'b0, 13'h380);
      applyStimulus(12'h1C0, 12'h1C0, 1'b0, 1'b1);
      expectLiteral("pwr_wait", 1'b0, 1'b0, 13'h380);
      waitCycles(200);
      expectLiteral("pwr_restart", 1'b0, 1'b0, 13'h380);

      // Falling threshold: 0x1B0 returns to IDLE one edge after capture
      applyStimulus(12'h0D8, 12'h0D8, 1'b1, 1'b1);
      expectLiteral("hyst_sum", 1'b0, 1'b0, 13'h1B0);
      waitCycles(1);
      expectLiteral("hyst_idle", 1'b1, 1'b0, 13'h1B0);

      // Rising threshold: 0x1F0 stays IDLE, 0x210 arms WAIT
      applyStimulus(12'h0F8, 12'h0F8, 1'b1, 1'b1);
      waitCycles(3);
      expectLiteral("idle_hold", 1'b1, 1'b0, 13'h1F0);
      applyStimulus(12'h108, 12'h108, 1'b1, 1'b1);
      expectLiteral("rearm_pre", 1'b1, 1'b0, 13'h210);
      waitCycles(1);
      expectLiteral("rearm_wait", 1'b0, 1'b0, 13'h210);

      // Asynchronous reset mid-WAIT, checked before any clock edge
      waitCycles(50);
      #2;
      rst_n = 1'b0;
      expectLiteral("reset_async", 1'b1, 1'b0, 13'h000);
      waitCycles(2);
      rst_n = 1'b1;
      waitCycles(4);
      expectLiteral("post_reset", 1'b1, 1'b0, 13'h000);

      waitCycles(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
